// File: rtl/sram_like_data_responder.sv
`default_nettype none
// ============================================================================
// Module      : sram_like_data_responder
// Description : Responder end of the data-side SRAM-like interface. Applies
//               byte-lane writes to an internal word memory at acceptance and
//               returns in-order data_ok/rdata responses a fixed minimum
//               number of cycles after each request was accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_like_data_responder #(
  parameter int AW      = 10,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata
);

  // Queue pointer width; a one-entry queue still gets a one-bit pointer and
  // two storage slots, occupancy being limited by the count.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int QN = 1 << PW;
  localparam int CW = $clog2(DEPTH + 1);
  // Timer wide enough that the modulo age of the head never aliases.
  localparam int TW = $clog2(LATENCY + DEPTH + 1) + 2;
  localparam int MW = 1 << AW;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [TW-1:0] LAT_T     = TW'(LATENCY);

  logic [31:0]    mem    [MW];
  logic [31:0]    q_data [QN];
  logic [TW-1:0]  q_ts   [QN];

  logic [PW-1:0]  r_head;
  logic [PW-1:0]  r_tail;
  logic [CW-1:0]  r_count;
  logic [TW-1:0]  r_timer;
  logic           r_ok;
  logic [31:0]    r_rdata;

  logic [AW-1:0]  w_idx;
  logic [1:0]     w_off;
  logic [3:0]     w_be;
  logic           w_accept;
  logic [31:0]    w_entry_data;
  logic [CW-1:0]  w_rem;
  logic [PW-1:0]  w_nhead;
  logic           w_cand_valid;
  logic [TW-1:0]  w_cand_ts;
  logic [31:0]    w_cand_data;
  logic [TW-1:0]  w_age;
  logic           w_ready;
  logic           unused_addr_bits;

  // Upper address bits alias onto the same words.
  assign unused_addr_bits = ^{1'b0, data_addr[31:AW+2]};

  assign w_idx = data_addr[AW+1:2];
  assign w_off = data_addr[1:0];

  // A full queue blocks acceptance even in a cycle where the head is leaving.
  assign data_addr_ok = data_req & ~hold & (r_count < DEPTH_CNT);
  assign w_accept     = data_addr_ok;

  // Reads snapshot the word at acceptance; writes answer with zero data.
  assign w_entry_data = data_wr ? 32'h0 : mem[w_idx];

  // Byte-lane enables from size and offset; unsupported pairs enable nothing.
  always_comb begin
    w_be = 4'b0000;
    case (data_size)
      2'd0: w_be = 4'b0001 << w_off;
      2'd1: begin
        if (w_off == 2'd0)      w_be = 4'b0011;
        else if (w_off == 2'd2) w_be = 4'b1100;
      end
      2'd2: w_be = 4'b1111;
      default: begin
        if (w_off == 2'd0)      w_be = 4'b0111;
        else if (w_off == 2'd1) w_be = 4'b1110;
      end
    endcase
  end

  // The head for next cycle skips the entry answered this cycle, which
  // leaves the queue at this edge.
  assign w_rem   = r_count - CW'(r_ok);
  assign w_nhead = r_head + PW'(r_ok);

  // Pick the entry that will be at the head next cycle: the oldest remaining
  // one, or the request being accepted now if nothing else is left.
  always_comb begin
    w_cand_valid = 1'b0;
    w_cand_ts    = r_timer;
    w_cand_data  = 32'h0;
    if (w_rem != '0) begin
      w_cand_valid = 1'b1;
      w_cand_ts    = q_ts[w_nhead];
      w_cand_data  = q_data[w_nhead];
    end else if (w_accept) begin
      w_cand_valid = 1'b1;
      w_cand_ts    = r_timer;
      w_cand_data  = w_entry_data;
    end
  end

  // Age the candidate will have next cycle; modulo arithmetic survives wrap.
  assign w_age   = r_timer + TW'(1) - w_cand_ts;
  assign w_ready = w_cand_valid & (w_age >= LAT_T);

  // Control state: timer, queue pointers/occupancy and registered response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timer <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_ok    <= 1'b0;
      r_rdata <= 32'h0;
    end else begin
      r_timer <= r_timer + 1'b1;
      r_ok    <= w_ready;
      r_rdata <= w_ready ? w_cand_data : 32'h0;
      r_head  <= w_nhead;
      if (w_accept) begin
        r_tail <= r_tail + 1'b1;
      end
      r_count <= r_count + CW'(w_accept) - CW'(r_ok);
    end
  end

  // Queue payload: acceptance time stamp and response data.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      q_ts[r_tail]   <= r_timer;
      q_data[r_tail] <= w_entry_data;
    end
  end

  // Word memory, written lane by lane at acceptance; never reset.
  always_ff @(posedge clk) begin
    if (w_accept && data_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          mem[w_idx][8*b +: 8] <= data_wdata[8*b +: 8];
        end
      end
    end
  end

  assign data_data_ok = r_ok;
  assign data_rdata   = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_like_data_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_like_data_responder
// Description : Self-checking bench for sram_like_data_responder: table of
//               byte-lane vectors, hand sequences for multi-cycle corners and
//               randomized traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_like_data_responder;

  localparam int AWP = 10;
  localparam int DEP = 4;
  localparam int LAT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  sram_like_data_responder #(
    .AW      (AWP),
    .DEPTH   (DEP),
    .LATENCY (LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .hold         (hold),
    .data_req     (req),
    .data_wr      (wr),
    .data_size    (size),
    .data_addr    (addr),
    .data_wdata   (wdata),
    .data_addr_ok (addr_ok),
    .data_data_ok (data_ok),
    .data_rdata   (rdata)
  );

  always #5 clk = ~clk;

  // Reference model: pending responses with their acceptance cycle, plus memory.
  typedef struct { int t; logic [31:0] d; } ent_t;
  ent_t        mq[$];
  logic [31:0] mm [0:(1<<AWP)-1];

  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic        s_acc;
  logic        s_ok;
  logic [31:0] s_rd;
  int          s_cyc;
  int          resp_cyc[$];
  logic [31:0] resp_dat[$];
  logic [31:0] iw [16];

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp;
    string       nm;
  } vec_t;
  vec_t tv [14];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got %h, expected %h", nm, cyc, act, exp);
  endtask

  task automatic timeout_fail(input string nm);
    n_checks++;
    $display("FAIL %s @cycle %0d: got timeout, expected event", nm, cyc);
  endtask

  // Bit mask of the bytes a request writes, straight from the lane rules.
  function automatic logic [31:0] lane_mask(input logic [1:0] sz, input logic [1:0] off);
    int o;
    o = int'(off);
    case (sz)
      2'd0: return 32'h0000_00FF << (8 * o);
      2'd1: return (o == 0 || o == 2) ? (32'h0000_FFFF << (8 * o)) : 32'h0;
      2'd2: return 32'hFFFF_FFFF;
      default: return (o == 0) ? 32'h00FF_FFFF : ((o == 1) ? 32'hFFFF_FF00 : 32'h0);
    endcase
  endfunction

  // One clock: compare outputs mid-cycle, then advance the model at the edge.
  task automatic tick();
    logic        e_acc;
    logic        e_ok;
    logic [31:0] e_rd;
    logic [31:0] m;
    int          idx;
    @(negedge clk);
    if (!rst) mq.delete();
    e_acc = req && !hold && (mq.size() < DEP);
    e_ok  = rst && (mq.size() > 0) && ((cyc - mq[0].t) >= LAT);
    e_rd  = e_ok ? mq[0].d : 32'h0;
    check("addr_ok", 32'(addr_ok), 32'(e_acc));
    check("data_ok", 32'(data_ok), 32'(e_ok));
    check("rdata", rdata, e_rd);
    s_acc = addr_ok;
    s_ok  = data_ok;
    s_rd  = rdata;
    s_cyc = cyc;
    if (data_ok) begin
      resp_cyc.push_back(cyc);
      resp_dat.push_back(rdata);
    end
    @(posedge clk);
    if (rst) begin
      if (e_ok) void'(mq.pop_front());
      if (e_acc) begin
        idx = int'((addr >> 2) % (1 << AWP));
        mq.push_back('{cyc, wr ? 32'h0 : mm[idx]});
        if (wr) begin
          m = lane_mask(size, addr[1:0]);
          mm[idx] = (mm[idx] & ~m) | (wdata & m);
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, output int acyc);
    req = 1'b1; wr = w; size = sz; addr = a; wdata = wd;
    acyc = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (s_acc) begin
        acyc = s_cyc;
        break;
      end
    end
    req = 1'b0;
    if (acyc < 0) timeout_fail("accept");
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && mq.size() > 0; i++) tick();
    if (mq.size() > 0) timeout_fail("drain");
  endtask

  task automatic wait_resps(input int n);
    for (int i = 0; i < 60 && resp_cyc.size() < n; i++) tick();
    if (resp_cyc.size() < n) timeout_fail("response");
  endtask

  task automatic clear_resps();
    resp_cyc.delete();
    resp_dat.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int acc[6];
    int t;
    int nacc;

    rst = 1'b1; hold = 1'b0; req = 1'b0; wr = 1'b0;
    size = 2'd0; addr = 32'h0; wdata = 32'h0;
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();

    // Known contents for the 16 words at 0x100.
    for (int k = 0; k < 16; k++) begin
      iw[k] = $urandom;
      issue(1'b1, 2'd2, 32'h100 + 32'(4 * k), iw[k], a0);
    end
    drain();

    // Byte-lane vectors: each request completes before the next is issued.
    tv[0]  = '{1'b1, 2'd2, 32'h40, 32'h1122_3344, 32'h0,         "sw_word"};
    tv[1]  = '{1'b1, 2'd0, 32'h41, 32'h0000_AA00, 32'h0,         "sb_off1"};
    tv[2]  = '{1'b1, 2'd1, 32'h42, 32'hBEEF_0000, 32'h0,         "sh_off2"};
    tv[3]  = '{1'b0, 2'd2, 32'h40, 32'h0,         32'hBEEF_AA44, "rd_after_sb_sh"};
    tv[4]  = '{1'b1, 2'd3, 32'h41, 32'h9988_7766, 32'h0,         "s3_off1"};
    tv[5]  = '{1'b0, 2'd2, 32'h40, 32'h0,         32'h9988_7744, "rd_after_s3_off1"};
    tv[6]  = '{1'b1, 2'd1, 32'h41, 32'hFFFF_FFFF, 32'h0,         "sh_off1_ignored"};
    tv[7]  = '{1'b0, 2'd0, 32'h43, 32'h0,         32'h9988_7744, "rd_byte_full_word"};
    tv[8]  = '{1'b1, 2'd0, 32'h43, 32'hCC00_0000, 32'h0,         "sb_off3"};
    tv[9]  = '{1'b0, 2'd2, 32'h40, 32'h0,         32'hCC88_7744, "rd_after_sb_off3"};
    tv[10] = '{1'b1, 2'd3, 32'h40, 32'h0012_3456, 32'h0,         "s3_off0"};
    tv[11] = '{1'b0, 2'd2, 32'h40, 32'h0,         32'hCC12_3456, "rd_after_s3_off0"};
    tv[12] = '{1'b1, 2'd3, 32'h42, 32'hFFFF_FFFF, 32'h0,         "s3_off2_ignored"};
    tv[13] = '{1'b0, 2'd2, 32'h40, 32'h0,         32'hCC12_3456, "rd_after_ignored"};
    for (int i = 0; i < 14; i++) begin
      drain();
      clear_resps();
      issue(tv[i].w, tv[i].sz, tv[i].a, tv[i].wd, a0);
      wait_resps(1);
      if (resp_dat.size() > 0) check(tv[i].nm, resp_dat[0], tv[i].exp);
    end

    // Read-after-write to the same word in consecutive cycles.
    drain();
    clear_resps();
    req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h80; wdata = 32'hDEAD_BEEF;
    tick();
    t = s_cyc;
    check("raw_wr_accept", 32'(s_acc), 32'd1);
    wr = 1'b0;
    tick();
    check("raw_rd_accept", 32'(s_acc), 32'd1);
    req = 1'b0;
    wait_resps(2);
    if (resp_cyc.size() >= 2) begin
      check("raw_wr_ok_cycle", 32'(resp_cyc[0]), 32'(t + LAT));
      check("raw_wr_rdata", resp_dat[0], 32'h0);
      check("raw_rd_ok_cycle", 32'(resp_cyc[1]), 32'(t + LAT + 1));
      check("raw_rd_rdata", resp_dat[1], 32'hDEAD_BEEF);
    end

    // Full queue: six back-to-back reads with four entries.
    drain();
    clear_resps();
    for (int k = 0; k < 6; k++) begin
      issue(1'b0, 2'd2, 32'h100 + 32'(4 * k), 32'h0, acc[k]);
      req = 1'b1;
    end
    req = 1'b0;
    wait_resps(6);
    for (int k = 1; k < 4; k++) check("full_b2b_accept", 32'(acc[k]), 32'(acc[0] + k));
    if (resp_cyc.size() > 0) check("full_5th_after_pop", 32'(acc[4]), 32'(resp_cyc[0] + 1));
    check("full_resp_count", 32'(resp_cyc.size()), 32'd6);
    for (int k = 0; k < resp_cyc.size() && k < 6; k++) begin
      check("full_rdata", resp_dat[k], iw[k]);
      check("full_ok_cycle", 32'(resp_cyc[k]), 32'(acc[k] + LAT));
    end

    // hold: request held high but nothing accepted until release.
    drain();
    clear_resps();
    hold = 1'b1; req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h104;
    nacc = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (s_acc) nacc++;
    end
    check("hold_no_accept", 32'(nacc), 32'd0);
    check("hold_no_data_ok", 32'(resp_cyc.size()), 32'd0);
    hold = 1'b0;
    tick();
    check("hold_release_accept", 32'(s_acc), 32'd1);
    req = 1'b0;
    drain();

    // Reset with three requests pending.
    clear_resps();
    for (int k = 0; k < 3; k++) begin
      issue(1'b0, 2'd2, 32'h100 + 32'(4 * k), 32'h0, a0);
      req = 1'b1;
    end
    req = 1'b0;
    tick();
    check("pre_reset_pending", 32'(mq.size()), 32'd3);
    rst = 1'b0;
    clear_resps();
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    check("reset_no_late_pulse", 32'(resp_cyc.size()), 32'd0);
    issue(1'b0, 2'd2, 32'h10C, 32'h0, a0);
    wait_resps(1);
    if (resp_cyc.size() > 0) begin
      check("reset_first_latency", 32'(resp_cyc[0]), 32'(a0 + LAT));
      check("reset_first_rdata", resp_dat[0], iw[3]);
    end

    // Upper address bits alias onto the same word.
    drain();
    clear_resps();
    issue(1'b1, 2'd2, 32'h0, 32'hCAFE_F00D, a0);
    issue(1'b0, 2'd2, 32'(4 << AWP), 32'h0, a0);
    issue(1'b0, 2'd2, 32'hFFFF_F000, 32'h0, a0);
    wait_resps(3);
    if (resp_dat.size() >= 3) begin
      check("alias_rdata", resp_dat[1], 32'hCAFE_F00D);
      check("alias_high_rdata", resp_dat[2], 32'hCAFE_F00D);
    end

    // Randomized traffic over the initialised words, aliased and misaligned.
    drain();
    for (int i = 0; i < 600; i++) begin
      req   = ($urandom % 4) != 0;
      hold  = ($urandom % 5) == 0;
      wr    = $urandom % 2;
      size  = 2'($urandom % 4);
      addr  = ($urandom & 32'hFFFF_F000) | 32'h100 | 32'($urandom_range(0, 63));
      wdata = $urandom;
      tick();
    end
    req = 1'b0;
    hold = 1'b0;
    drain();
    for (int i = 0; i < 3; i++) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
